// File: rtl/fix_field_if.sv
// Byte-stream in / parsed-beat out bundle for fix_field_parser.
// FIX_CHECKSUM_EN adds the chk_* checksum signals.
interface fix_field_if #(
    parameter int TAG_W = 16,
    parameter int LEN_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_eof;
    logic [LEN_W-1:0] out_len;
    logic             out_err;
    logic [1:0]       out_err_code;
`ifdef FIX_CHECKSUM_EN
    logic             chk_valid;
    logic             chk_err;
    logic [7:0]       chk_sum;
`endif

    // master is the parser; slave is the byte source / beat sink around it
    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_eof, out_len,
               out_err, out_err_code
`ifdef FIX_CHECKSUM_EN
        , output chk_valid, chk_err, chk_sum
`endif
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_eof, out_len,
               out_err, out_err_code
`ifdef FIX_CHECKSUM_EN
        , input chk_valid, chk_err, chk_sum
`endif
    );
endinterface

// File: rtl/fix_field_parser.sv
// Splits a FIX byte stream into tag/value fields with one registered output stage.
// Optional FIX_CHECKSUM_EN adds the tag-10 checksum verification outputs.
module fix_field_parser #(
    parameter int         TAG_W = 16,
    parameter int         LEN_W = 12,
    parameter logic [7:0] SOH_C = 8'h01,
    parameter logic [7:0] SEP_C = 8'h3D
) (
    input  logic        clk,
    input  logic        rst,
    fix_field_if.master bus
);
    typedef enum logic [1:0] {
        ST_TAG   = 2'd0,
        ST_VALUE = 2'd1,
        ST_SKIP  = 2'd2
    } state_t;

    localparam logic [1:0]       ERR_LEN_C   = 2'd0;
    localparam logic [1:0]       ERR_DIGIT_C = 2'd1;
    localparam logic [1:0]       ERR_OVF_C   = 2'd2;
    localparam logic [1:0]       ERR_EMPTY_C = 2'd3;
    localparam logic [LEN_W-1:0] LEN_MAX_C   = {LEN_W{1'b1}};

    state_t           state_r;
    logic [TAG_W-1:0] acc_r;
    logic             digit_seen_r;
    logic [LEN_W-1:0] len_r;
    logic [TAG_W-1:0] tag_r;
    logic             out_valid_r;
    logic [7:0]       out_data_r;
    logic [TAG_W-1:0] out_tag_r;
    logic             out_eof_r;
    logic [LEN_W-1:0] out_len_r;
    logic             out_err_r;
    logic [1:0]       out_err_code_r;

    logic             in_ready_s;
    logic             accept_s;
    logic             is_digit_s;
    logic             is_sep_s;
    logic             is_soh_s;
    logic [3:0]       digit_val_s;
    logic [TAG_W+3:0] tag_wide_s;
    logic             tag_ovf_s;

    state_t           state_nx_s;
    logic [TAG_W-1:0] acc_nx_s;
    logic             seen_nx_s;
    logic [LEN_W-1:0] len_nx_s;
    logic [TAG_W-1:0] tag_nx_s;
    logic             beat_s;
    logic [7:0]       b_data_s;
    logic [TAG_W-1:0] b_tag_s;
    logic             b_eof_s;
    logic [LEN_W-1:0] b_len_s;
    logic             b_err_s;
    logic [1:0]       b_code_s;

    assign in_ready_s  = bus.out_ready || !out_valid_r;
    assign accept_s    = bus.in_valid && in_ready_s;
    assign is_digit_s  = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
    assign is_sep_s    = (bus.in_data == SEP_C);
    assign is_soh_s    = (bus.in_data == SOH_C);
    assign digit_val_s = bus.in_data[3:0];
    // Four guard bits hold acc*10+9 exactly, so any nonzero guard bit means overflow
    assign tag_wide_s  = ({4'b0000, acc_r} * (TAG_W+4)'(10)) + {{TAG_W{1'b0}}, digit_val_s};
    assign tag_ovf_s   = (tag_wide_s[TAG_W+3:TAG_W] != 4'b0000);

    // Field parser: next state and the beat (if any) produced by the accepted byte
    always_comb begin
        state_nx_s = state_r;
        acc_nx_s   = acc_r;
        seen_nx_s  = digit_seen_r;
        len_nx_s   = len_r;
        tag_nx_s   = tag_r;
        beat_s     = 1'b0;
        b_data_s   = bus.in_data;
        b_tag_s    = acc_r;
        b_eof_s    = 1'b0;
        b_len_s    = len_r;
        b_err_s    = 1'b0;
        b_code_s   = ERR_LEN_C;
        if (accept_s) begin
            case (state_r)
                ST_TAG: begin
                    if (is_digit_s) begin
                        if (tag_ovf_s) begin
                            beat_s     = 1'b1;
                            b_err_s    = 1'b1;
                            b_code_s   = ERR_OVF_C;
                            b_tag_s    = tag_wide_s[TAG_W-1:0];
                            state_nx_s = ST_SKIP;
                        end else begin
                            acc_nx_s  = tag_wide_s[TAG_W-1:0];
                            seen_nx_s = 1'b1;
                        end
                    end else if (is_sep_s) begin
                        if (digit_seen_r) begin
                            tag_nx_s   = acc_r;
                            len_nx_s   = {LEN_W{1'b0}};
                            state_nx_s = ST_VALUE;
                        end else begin
                            beat_s     = 1'b1;
                            b_err_s    = 1'b1;
                            b_code_s   = ERR_EMPTY_C;
                            state_nx_s = ST_SKIP;
                        end
                    end else if (is_soh_s) begin
                        // A delimiter already ends the field, so parsing resumes at the next tag
                        beat_s     = 1'b1;
                        b_err_s    = 1'b1;
                        b_code_s   = digit_seen_r ? ERR_DIGIT_C : ERR_EMPTY_C;
                        acc_nx_s   = {TAG_W{1'b0}};
                        seen_nx_s  = 1'b0;
                        state_nx_s = ST_TAG;
                    end else begin
                        beat_s     = 1'b1;
                        b_err_s    = 1'b1;
                        b_code_s   = ERR_DIGIT_C;
                        state_nx_s = ST_SKIP;
                    end
                end
                ST_VALUE: begin
                    b_tag_s = tag_r;
                    if (is_soh_s) begin
                        beat_s     = 1'b1;
                        b_eof_s    = 1'b1;
                        b_data_s   = SOH_C;
                        b_len_s    = len_r;
                        acc_nx_s   = {TAG_W{1'b0}};
                        seen_nx_s  = 1'b0;
                        len_nx_s   = {LEN_W{1'b0}};
                        state_nx_s = ST_TAG;
                    end else if (len_r == LEN_MAX_C) begin
                        beat_s     = 1'b1;
                        b_err_s    = 1'b1;
                        b_code_s   = ERR_LEN_C;
                        state_nx_s = ST_SKIP;
                    end else begin
                        beat_s   = 1'b1;
                        len_nx_s = len_r + LEN_W'(1);
                        b_len_s  = len_r + LEN_W'(1);
                    end
                end
                ST_SKIP: begin
                    if (is_soh_s) begin
                        acc_nx_s   = {TAG_W{1'b0}};
                        seen_nx_s  = 1'b0;
                        state_nx_s = ST_TAG;
                    end else begin
                        state_nx_s = ST_SKIP;
                    end
                end
                default: begin
                    state_nx_s = ST_TAG;
                    acc_nx_s   = {TAG_W{1'b0}};
                    seen_nx_s  = 1'b0;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Parser state and the single output register stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_TAG;
            acc_r          <= {TAG_W{1'b0}};
            digit_seen_r   <= 1'b0;
            len_r          <= {LEN_W{1'b0}};
            tag_r          <= {TAG_W{1'b0}};
            out_valid_r    <= 1'b0;
            out_data_r     <= 8'h00;
            out_tag_r      <= {TAG_W{1'b0}};
            out_eof_r      <= 1'b0;
            out_len_r      <= {LEN_W{1'b0}};
            out_err_r      <= 1'b0;
            out_err_code_r <= 2'd0;
        end else begin
            state_r      <= state_nx_s;
            acc_r        <= acc_nx_s;
            digit_seen_r <= seen_nx_s;
            len_r        <= len_nx_s;
            tag_r        <= tag_nx_s;
            if (accept_s && beat_s) begin
                out_valid_r    <= 1'b1;
                out_data_r     <= b_data_s;
                out_tag_r      <= b_tag_s;
                out_eof_r      <= b_eof_s;
                out_len_r      <= b_len_s;
                out_err_r      <= b_err_s;
                out_err_code_r <= b_code_s;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
                out_eof_r   <= 1'b0;
                out_err_r   <= 1'b0;
            end
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_data     = out_data_r;
    assign bus.out_tag      = out_tag_r;
    assign bus.out_eof      = out_eof_r;
    assign bus.out_len      = out_len_r;
    assign bus.out_err      = out_err_r;
    assign bus.out_err_code = out_err_code_r;

`ifdef FIX_CHECKSUM_EN
    logic [7:0] sum_r;
    logic [7:0] fsum_r;
    logic       in_chk_r;
    logic [7:0] cval_r;
    logic       cbad_r;
    logic       chk_valid_r;
    logic       chk_err_r;
    logic [7:0] chk_sum_r;

    logic [7:0] sum_nx_s;
    logic [7:0] fsum_nx_s;
    logic       in_chk_nx_s;
    logic [7:0] cval_nx_s;
    logic       cbad_nx_s;
    logic       chk_beat_s;

    // Tag bytes wait in fsum until the tag is known, since tag-10 bytes are excluded
    always_comb begin
        sum_nx_s    = sum_r;
        fsum_nx_s   = fsum_r;
        in_chk_nx_s = in_chk_r;
        cval_nx_s   = cval_r;
        cbad_nx_s   = cbad_r;
        chk_beat_s  = 1'b0;
        if (accept_s) begin
            case (state_r)
                ST_TAG: begin
                    if (is_digit_s && !tag_ovf_s) begin
                        fsum_nx_s = fsum_r + bus.in_data;
                    end else if (is_sep_s && digit_seen_r && (acc_r == TAG_W'(10))) begin
                        fsum_nx_s   = 8'h00;
                        in_chk_nx_s = 1'b1;
                        cval_nx_s   = 8'h00;
                        cbad_nx_s   = 1'b0;
                    end else begin
                        sum_nx_s  = sum_r + fsum_r + bus.in_data;
                        fsum_nx_s = 8'h00;
                    end
                end
                ST_VALUE: begin
                    if (!in_chk_r) begin
                        sum_nx_s = sum_r + bus.in_data;
                    end else if (is_soh_s) begin
                        chk_beat_s  = 1'b1;
                        sum_nx_s    = 8'h00;
                        in_chk_nx_s = 1'b0;
                    end else if (len_r == LEN_MAX_C) begin
                        in_chk_nx_s = 1'b0;
                        sum_nx_s    = sum_r + bus.in_data;
                    end else if (is_digit_s) begin
                        cval_nx_s = (cval_r * 8'd10) + {4'b0000, digit_val_s};
                    end else begin
                        cbad_nx_s = 1'b1;
                    end
                end
                ST_SKIP: begin
                    sum_nx_s = sum_r + bus.in_data;
                end
                default: begin
                    sum_nx_s = sum_r;
                end
            endcase
        end else begin
            sum_nx_s = sum_r;
        end
    end

    // Checksum state and the chk_* fields that travel with the output beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_r       <= 8'h00;
            fsum_r      <= 8'h00;
            in_chk_r    <= 1'b0;
            cval_r      <= 8'h00;
            cbad_r      <= 1'b0;
            chk_valid_r <= 1'b0;
            chk_err_r   <= 1'b0;
            chk_sum_r   <= 8'h00;
        end else begin
            sum_r    <= sum_nx_s;
            fsum_r   <= fsum_nx_s;
            in_chk_r <= in_chk_nx_s;
            cval_r   <= cval_nx_s;
            cbad_r   <= cbad_nx_s;
            if (accept_s && beat_s) begin
                chk_valid_r <= chk_beat_s;
                if (chk_beat_s) begin
                    chk_sum_r <= sum_r;
                    chk_err_r <= cbad_r || (cval_r != sum_r);
                end
            end else if (bus.out_ready) begin
                chk_valid_r <= 1'b0;
            end
        end
    end

    assign bus.chk_valid = chk_valid_r;
    assign bus.chk_err   = chk_err_r;
    assign bus.chk_sum   = chk_sum_r;
`endif
endmodule

// File: tb/tb_fix_field_parser.sv
// Directed bench for fix_field_parser: default instance plus a TAG_W=8/LEN_W=2 instance.
module tb_fix_field_parser;
    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] tag;
        logic        eof;
        logic [11:0] len;
        logic        err;
        logic [1:0]  code;
        logic        cv;
        logic        ce;
        logic [7:0]  cs;
    } beat_t;

    logic  clk;
    logic  rst;
    int    n_checks;
    int    n_errs;
    int    viol_cnt;
    int    hold_cnt;
    bit    tog_en;
    bit    held_v;
    beat_t held_b;
    beat_t last_b;
    beat_t q_a[$];
    beat_t q_b[$];

    fix_field_if #(.TAG_W(16), .LEN_W(12)) bus_a ();
    fix_field_if #(.TAG_W(8),  .LEN_W(2))  bus_b ();

    fix_field_parser #(.TAG_W(16), .LEN_W(12)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
    fix_field_parser #(.TAG_W(8),  .LEN_W(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic beat_t grab_a();
        beat_t b;
        b = '0;
        b.data = bus_a.out_data; b.tag = bus_a.out_tag; b.eof = bus_a.out_eof;
        b.len = bus_a.out_len; b.err = bus_a.out_err; b.code = bus_a.out_err_code;
`ifdef FIX_CHECKSUM_EN
        b.cv = bus_a.chk_valid; b.ce = bus_a.chk_err; b.cs = bus_a.chk_sum;
`endif
        return b;
    endfunction

    function automatic beat_t grab_b();
        beat_t b;
        b = '0;
        b.data = bus_b.out_data; b.tag = {8'h00, bus_b.out_tag}; b.eof = bus_b.out_eof;
        b.len = {10'd0, bus_b.out_len}; b.err = bus_b.out_err; b.code = bus_b.out_err_code;
        return b;
    endfunction

    // Beat collectors plus the hold/backpressure watcher on instance A
    always @(posedge clk) begin
        if (bus_a.out_valid && bus_a.out_ready) q_a.push_back(grab_a());
        if (bus_b.out_valid && bus_b.out_ready) q_b.push_back(grab_b());
        if (bus_a.out_valid && !bus_a.out_ready) begin
            hold_cnt = hold_cnt + 1;
            if (bus_a.in_ready) viol_cnt = viol_cnt + 1;
            if (held_v && (grab_a() != held_b)) viol_cnt = viol_cnt + 1;
            held_v = 1'b1;
            held_b = grab_a();
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (tog_en) bus_a.out_ready = ~bus_a.out_ready;
        end
    end

    task automatic check_eq(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errs = n_errs + 1;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] b);
        int   n;
        logic rdy;
        n = 0;
        @(negedge clk);
        #1;
        if (sel) begin bus_b.in_valid = 1'b1; bus_b.in_data = b; end
        else     begin bus_a.in_valid = 1'b1; bus_a.in_data = b; end
        forever begin
            rdy = sel ? bus_b.in_ready : bus_a.in_ready;
            @(posedge clk);
            if (rdy) break;
            n = n + 1;
            if (n > 50) begin
                check_eq("send_timeout", 32'd0, 32'd1);
                break;
            end
            @(negedge clk);
            #1;
        end
        #1;
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
    endtask

    // '|' stands for SOH in stimulus strings
    task automatic send_str(input bit sel, input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "|") send(sel, 8'h01);
            else             send(sel, s[i]);
        end
    endtask

    task automatic expect_beat(input bit sel, input string nm, input logic [7:0] data,
                               input logic [15:0] tag, input logic eof, input logic err,
                               input logic [1:0] code, input logic [11:0] len);
        int n;
        n = 0;
        while (((sel ? q_b.size() : q_a.size()) == 0) && (n < 40)) begin
            @(negedge clk);
            n = n + 1;
        end
        if ((sel ? q_b.size() : q_a.size()) == 0) begin
            check_eq({nm, ".timeout"}, 32'd0, 32'd1);
        end else begin
            last_b = sel ? q_b.pop_front() : q_a.pop_front();
            check_eq({nm, ".data"}, {24'd0, last_b.data}, {24'd0, data});
            check_eq({nm, ".tag"},  {16'd0, last_b.tag},  {16'd0, tag});
            check_eq({nm, ".eof"},  {31'd0, last_b.eof},  {31'd0, eof});
            check_eq({nm, ".err"},  {31'd0, last_b.err},  {31'd0, err});
            if (err) check_eq({nm, ".code"}, {30'd0, last_b.code}, {30'd0, code});
            if (eof) check_eq({nm, ".len"},  {20'd0, last_b.len},  {20'd0, len});
        end
    endtask

    task automatic expect_idle(input bit sel, input string nm);
        repeat (4) @(negedge clk);
        check_eq(nm, sel ? q_b.size() : q_a.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_errs = 0; viol_cnt = 0; hold_cnt = 0;
        tog_en = 1'b0; held_v = 1'b0; held_b = '0; last_b = '0;
        bus_a.in_valid = 1'b0; bus_a.in_data = 8'h00; bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.in_data = 8'h00; bus_b.out_ready = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst.out_valid", {31'd0, bus_a.out_valid}, 32'd0);
        check_eq("rst.out_eof",   {31'd0, bus_a.out_eof},   32'd0);
        check_eq("rst.out_err",   {31'd0, bus_a.out_err},   32'd0);
        check_eq("rst.out_data",  {24'd0, bus_a.out_data},  32'd0);
        check_eq("rst.out_tag",   {16'd0, bus_a.out_tag},   32'd0);
        check_eq("rst.out_len",   {20'd0, bus_a.out_len},   32'd0);
        check_eq("rst.err_code",  {30'd0, bus_a.out_err_code}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst.in_ready", {31'd0, bus_a.in_ready}, 32'd1);

`ifdef FIX_CHECKSUM_EN
        // "8=F<SOH>" sums to 0x38+0x3D+0x46+0x01 = 188
        send_str(1'b0, "8=F|10=188|");
        expect_beat(1'b0, "ck.F",   8'h46, 16'd8,  1'b0, 1'b0, 2'd0, 12'd0);
        expect_beat(1'b0, "ck.e8",  8'h01, 16'd8,  1'b1, 1'b0, 2'd0, 12'd1);
        expect_beat(1'b0, "ck.d1",  8'h31, 16'd10, 1'b0, 1'b0, 2'd0, 12'd0);
        expect_beat(1'b0, "ck.d2",  8'h38, 16'd10, 1'b0, 1'b0, 2'd0, 12'd0);
        expect_beat(1'b0, "ck.d3",  8'h38, 16'd10, 1'b0, 1'b0, 2'd0, 12'd0);
        expect_beat(1'b0, "ck.e10", 8'h01, 16'd10, 1'b1, 1'b0, 2'd0, 12'd3);
        check_eq("ck.valid", {31'd0, last_b.cv}, 32'd1);
        check_eq("ck.err",   {31'd0, last_b.ce}, 32'd0);
        check_eq("ck.sum",   {24'd0, last_b.cs}, 32'd188);
        send_str(1'b0, "8=F|10=189|");
        repeat (5) expect_beat(1'b0, "ck2.skip", q_a.size() > 0 ? q_a[0].data : 8'h00,
                               q_a.size() > 0 ? q_a[0].tag : 16'd0, q_a.size() > 0 ? q_a[0].eof : 1'b0,
                               1'b0, 2'd0, q_a.size() > 0 ? q_a[0].len : 12'd0);
        expect_beat(1'b0, "ck2.e10", 8'h01, 16'd10, 1'b1, 1'b0, 2'd0, 12'd3);
        check_eq("ck2.valid", {31'd0, last_b.cv}, 32'd1);
        check_eq("ck2.err",   {31'd0, last_b.ce}, 32'd1);
        check_eq("ck2.sum",   {24'd0, last_b.cs}, 32'd188);
`endif

        // Partial field "12" must be forgotten across reset
        send_str(1'b0, "12");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send_str(1'b0, "7=Q|");
        expect_beat(1'b0, "rstmid.Q",   8'h51, 16'd7, 1'b0, 1'b0, 2'd0, 12'd0);
        expect_beat(1'b0, "rstmid.eof", 8'h01, 16'd7, 1'b1, 1'b0, 2'd0, 12'd1);

        send_str(1'b0, "35=D|");
        expect_beat(1'b0, "f35.D",   8'h44, 16'd35, 1'b0, 1'b0, 2'd0, 12'd0);
        expect_beat(1'b0, "f35.eof", 8'h01, 16'd35, 1'b1, 1'b0, 2'd0, 12'd1);

        send_str(1'b0, "9=|");
        expect_beat(1'b0, "f9.eof", 8'h01, 16'd9, 1'b1, 1'b0, 2'd0, 12'd0);
        expect_idle(1'b0, "f9.idle");

        send_str(1'b0, "3A=x|44=1|");
        expect_beat(1'b0, "f3A.err", 8'h41, 16'd3,  1'b0, 1'b1, 2'd1, 12'd0);
        expect_beat(1'b0, "f44.1",   8'h31, 16'd44, 1'b0, 1'b0, 2'd0, 12'd0);
        expect_beat(1'b0, "f44.eof", 8'h01, 16'd44, 1'b1, 1'b0, 2'd0, 12'd1);
        expect_idle(1'b0, "f44.idle");

        send_str(1'b0, "=5||12|8=K|");
        expect_beat(1'b0, "sep0.err", 8'h3D, 16'd0,  1'b0, 1'b1, 2'd3, 12'd0);
        expect_beat(1'b0, "soh0.err", 8'h01, 16'd0,  1'b0, 1'b1, 2'd3, 12'd0);
        expect_beat(1'b0, "soh12.err",8'h01, 16'd12, 1'b0, 1'b1, 2'd1, 12'd0);
        expect_beat(1'b0, "f8.K",     8'h4B, 16'd8,  1'b0, 1'b0, 2'd0, 12'd0);
        expect_beat(1'b0, "f8.eof",   8'h01, 16'd8,  1'b1, 1'b0, 2'd0, 12'd1);

        send_str(1'b0, "65535=Q|");
        expect_beat(1'b0, "fmax.Q",   8'h51, 16'hFFFF, 1'b0, 1'b0, 2'd0, 12'd0);
        expect_beat(1'b0, "fmax.eof", 8'h01, 16'hFFFF, 1'b1, 1'b0, 2'd0, 12'd1);

        tog_en = 1'b1;
        send_str(1'b0, "55=ABC|");
        expect_beat(1'b0, "tog.A",   8'h41, 16'd55, 1'b0, 1'b0, 2'd0, 12'd0);
        expect_beat(1'b0, "tog.B",   8'h42, 16'd55, 1'b0, 1'b0, 2'd0, 12'd0);
        expect_beat(1'b0, "tog.C",   8'h43, 16'd55, 1'b0, 1'b0, 2'd0, 12'd0);
        expect_beat(1'b0, "tog.eof", 8'h01, 16'd55, 1'b1, 1'b0, 2'd0, 12'd3);
        tog_en = 1'b0;
        @(negedge clk);
        bus_a.out_ready = 1'b1;
        expect_idle(1'b0, "tog.idle");
        check_eq("tog.hold_violations", viol_cnt, 32'd0);
        check_eq("tog.holds_seen", {31'd0, hold_cnt > 0}, 32'd1);

        // TAG_W=8: 300 overflows on the third digit, tag reported as 300 mod 256
        send_str(1'b1, "300=1|255=1|");
        expect_beat(1'b1, "ovf.err",  8'h30, 16'd44,  1'b0, 1'b1, 2'd2, 12'd0);
        expect_beat(1'b1, "f255.1",   8'h31, 16'd255, 1'b0, 1'b0, 2'd0, 12'd0);
        expect_beat(1'b1, "f255.eof", 8'h01, 16'd255, 1'b1, 1'b0, 2'd0, 12'd1);
        expect_idle(1'b1, "f255.idle");

        // LEN_W=2: three value bytes fit, a fourth is too long
        send_str(1'b1, "5=ABC|5=ABCD|6=|");
        expect_beat(1'b1, "l3.A",    8'h41, 16'd5, 1'b0, 1'b0, 2'd0, 12'd0);
        expect_beat(1'b1, "l3.B",    8'h42, 16'd5, 1'b0, 1'b0, 2'd0, 12'd0);
        expect_beat(1'b1, "l3.C",    8'h43, 16'd5, 1'b0, 1'b0, 2'd0, 12'd0);
        expect_beat(1'b1, "l3.eof",  8'h01, 16'd5, 1'b1, 1'b0, 2'd0, 12'd3);
        expect_beat(1'b1, "l4.A",    8'h41, 16'd5, 1'b0, 1'b0, 2'd0, 12'd0);
        expect_beat(1'b1, "l4.B",    8'h42, 16'd5, 1'b0, 1'b0, 2'd0, 12'd0);
        expect_beat(1'b1, "l4.C",    8'h43, 16'd5, 1'b0, 1'b0, 2'd0, 12'd0);
        expect_beat(1'b1, "l4.err",  8'h44, 16'd5, 1'b0, 1'b1, 2'd0, 12'd0);
        expect_beat(1'b1, "f6.eof",  8'h01, 16'd6, 1'b1, 1'b0, 2'd0, 12'd0);
        expect_idle(1'b1, "f6.idle");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
